hazard_forward_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage MIPS core. Keeps its own shadow copy of the destination-register info for the EX, MEM and WB stages. From that it drives the 2-bit select of the two EX-stage operand muxes (4:1, 32-bit), and it detects load-use hazards, stalling IF/ID and inserting a bubble into EX. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_forward_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage core.
// Ports: id_* describe the ID instruction; fwd_*_sel, stall, ex_bubble, stall_count out.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
  } stg_t;

  stg_t              ex_q;
  stg_t              mem_q;
  stg_t              wb_q;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_use_rs;
  logic              ex_use_rt;

  logic              kill;
  logic              hit_rs;
  logic              hit_rt;

  function automatic logic [1:0] sel_for(
    input logic              use_r,
    input logic [REG_AW-1:0] r,
    input stg_t              m,
    input stg_t              w
  );
    logic [1:0] s;
    s = 2'b00;
    if (use_r && r != '0) begin
      // Youngest producer wins: MEM is checked before WB.
      if (m.wr && m.dst == r)
        s = 2'b01;
      else if (w.wr && w.dst == r)
        s = w.load ? 2'b11 : 2'b10;
    end
    return s;
  endfunction

  always_comb begin
    fwd_a_sel = sel_for(ex_use_rs, ex_rs, mem_q, wb_q);
    fwd_b_sel = sel_for(ex_use_rt, ex_rt, mem_q, wb_q);
  end

  assign hit_rs = id_use_rs && (id_rs == ex_q.dst);
  assign hit_rt = id_use_rt && (id_rt == ex_q.dst);

  // A squashed ID instruction can never cause a stall.
  assign stall = id_valid & ~flush
               & ex_q.load & ex_q.wr & (|ex_q.dst)
               & (hit_rs | hit_rt);

  assign kill      = stall | flush | ~id_valid;
  assign ex_bubble = ~(ex_q.wr | ex_use_rs | ex_use_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (kill) begin
        ex_q      <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_use_rs <= 1'b0;
        ex_use_rt <= 1'b0;
      end else begin
        ex_q.dst  <= id_dst;
        ex_q.wr   <= id_reg_write;
        ex_q.load <= id_mem_read;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_use_rs <= id_use_rs;
        ex_use_rt <= id_use_rt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && !(&stall_count))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: reference pipeline model plus directed cases.
// Small counter width so saturation is reachable.
module tb_hazard_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          id_use_rs, id_use_rt;
  logic          id_reg_write, id_mem_read, flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, ex_bubble;
  logic [CW-1:0] stall_count;

  int passed = 0;
  int total  = 0;

  hazard_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .ex_bubble(ex_bubble),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Instruction as seen by the model; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [AW-1:0] rs, rt, dst;
    logic          urs, urt, wr, ld;
  } ins_t;

  ins_t pipe [3];
  int   m_cnt;

  function automatic int need_stall();
    ins_t p;
    p = pipe[0];
    if (!id_valid || flush) return 0;
    if (!(p.ld && p.wr) || p.dst == 0) return 0;
    return int'((id_use_rs && id_rs == p.dst) ||
                (id_use_rt && id_rt == p.dst));
  endfunction

  // Nearest older writer of r supplies the value; $0 is never forwarded.
  function automatic int src_of(logic u, logic [AW-1:0] r);
    if (!u || r == 0) return 0;
    if (pipe[1].wr && pipe[1].dst == r) return 1;
    if (pipe[2].wr && pipe[2].dst == r) return pipe[2].ld ? 3 : 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
      m_cnt   <= 0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      if (need_stall() == 1 || flush || !id_valid)
        pipe[0] <= '0;
      else
        pipe[0] <= '{id_rs, id_rt, id_dst, id_use_rs,
                     id_use_rt, id_reg_write, id_mem_read};
      if (need_stall() == 1 && m_cnt < (1 << CW) - 1)
        m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    chk("m_fwd_a", int'(fwd_a_sel), src_of(pipe[0].urs, pipe[0].rs));
    chk("m_fwd_b", int'(fwd_b_sel), src_of(pipe[0].urt, pipe[0].rt));
    chk("m_stall", int'(stall), need_stall());
    chk("m_bubble", int'(ex_bubble),
        int'(!(pipe[0].wr || pipe[0].urs || pipe[0].urt)));
    chk("m_count", int'(stall_count), m_cnt);
  end

  // Apply one ID-stage instruction for a full cycle, return at its negedge.
  task automatic issue(logic v, logic [AW-1:0] rs, logic [AW-1:0] rt,
                       logic urs, logic urt, logic [AW-1:0] dst,
                       logic wr, logic ld, logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_dst = dst;
    id_reg_write = wr; id_mem_read = ld; flush = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(logic [AW-1:0] d, logic [AW-1:0] s, logic [AW-1:0] t);
    issue(1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(logic [AW-1:0] d, logic [AW-1:0] base);
    issue(1'b1, base, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dst = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    #12;
    chk("rst_bubble", int'(ex_bubble), 1);
    chk("rst_count", int'(stall_count), 0);
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd5);
    nop();
    chk("b2b_a", int'(fwd_a_sel), 1);
    chk("b2b_b", int'(fwd_b_sel), 0);

    // add $3 ; nop ; or $6,$7,$3
    alu(5'd3, 5'd1, 5'd2);
    nop();
    alu(5'd6, 5'd7, 5'd3);
    nop();
    chk("d2_b", int'(fwd_b_sel), 2);
    chk("d2_a", int'(fwd_a_sel), 0);

    // add $3 ; add $3 ; or $6,$7,$3 : MEM beats WB
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd3, 5'd4, 5'd5);
    alu(5'd6, 5'd7, 5'd3);
    nop();
    chk("prio_b", int'(fwd_b_sel), 1);

    // lw $8 ; add $9,$8,$8
    lw(5'd8, 5'd1);
    alu(5'd9, 5'd8, 5'd8);
    chk("lu_stall", int'(stall), 1);
    alu(5'd9, 5'd8, 5'd8);
    chk("lu_stall_off", int'(stall), 0);
    chk("lu_bubble", int'(ex_bubble), 1);
    nop();
    chk("lu_a", int'(fwd_a_sel), 3);
    chk("lu_b", int'(fwd_b_sel), 3);
    chk("lu_count", int'(stall_count), 1);

    // lw $0 ; consumer of $0
    lw(5'd0, 5'd1);
    alu(5'd9, 5'd0, 5'd0);
    chk("z_stall", int'(stall), 0);
    nop();
    chk("z_a", int'(fwd_a_sel), 0);
    chk("z_b", int'(fwd_b_sel), 0);

    // lw $8 ; consumer squashed by flush
    lw(5'd8, 5'd1);
    issue(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", int'(stall), 0);
    nop();
    chk("fl_bubble", int'(ex_bubble), 1);

    // Async reset mid-cycle while a hazard is pending
    lw(5'd8, 5'd1);
    alu(5'd9, 5'd8, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_a", int'(fwd_a_sel), 0);
    chk("ar_b", int'(fwd_b_sel), 0);
    chk("ar_stall", int'(stall), 0);
    chk("ar_bubble", int'(ex_bubble), 1);
    chk("ar_count", int'(stall_count), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Saturation: 19 load-use hazards into a 4-bit counter
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      lw(5'd8, 5'd1);
      alu(5'd9, 5'd8, 5'd2);
      if (i == 14) chk("sat_pre", int'(stall_count), 14);
    end
    nop();
    chk("sat_hold", int'(stall_count), 15);
    nop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
